// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StRtypeWb,
    StBranch,
    StJump,
    StAddiEx,
    StAddiWb,
    StIllegal
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mem_watchdog.sv
// Counts cycles a memory state waits on mem_ready and flags an abort at WAIT_MAX.
module mips_mem_watchdog #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;

  assign timeout = active && !mem_ready && (wait_cnt == 8'(WAIT_MAX));

  // Any exit from a memory state (ready or abort) restarts the count.
  always_comb begin
    wait_cnt_next = '0;
    if (active && !mem_ready && !timeout) begin
      wait_cnt_next = wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main control FSM for the multicycle MIPS datapath with memory watchdog.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to make the ILLEGAL state terminal until reset.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                mem_timeout,
  output logic                illegal_op
);

  state_e state;
  state_e state_next;
  logic   mem_active;
  logic   timeout;

  assign mem_active = (state == StFetch) || (state == StMemRd) || (state == StMemWr);

  mips_mem_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active    (mem_active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StFetch;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    mem_timeout   = timeout;
    illegal_op    = 1'b0;

    unique case (state)
      StFetch: begin
        alu_src_b = SRCB_FOUR;
        // An aborted fetch retries from the same PC: no strobe at all.
        if (!timeout) begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          if (mem_ready) state_next = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_next = StRtypeEx;
          OP_LW, OP_SW: state_next = StMemAddr;
          OP_BEQ:       state_next = StBranch;
          OP_J:         state_next = StJump;
          OP_ADDI:      state_next = StAddiEx;
          default:      state_next = StIllegal;
        endcase
      end
      StMemAddr: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        i_or_d   = 1'b1;
        mem_read = !timeout;
        if (timeout)        state_next = StFetch;
        else if (mem_ready) state_next = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = StFetch;
      end
      StMemWr: begin
        i_or_d    = 1'b1;
        mem_write = !timeout;
        if (timeout || mem_ready) state_next = StFetch;
      end
      StRtypeEx: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_FUNCT;
        state_next = StRtypeWb;
      end
      StRtypeWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_next    = StFetch;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        state_next = StFetch;
      end
      StAddiEx: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = StAddiWb;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        state_next = StFetch;
      end
      StIllegal: begin
        illegal_op = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        state_next = StIllegal;
`else
        state_next = StFetch;
`endif
      end
      default: state_next = StFetch;
    endcase

    // Reset is asynchronous, so outputs are forced quiet combinationally too.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      mem_timeout   = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback. Drives every datapath mux select, including the 2:1 register-destination and memory-to-register muxes, the ALU source muxes and the PC source mux, plus all write strobes. Waits on a memory ready handshake, with a watchdog counter that aborts stalled accesses.

Parameters:
OPCODE_W, 6, opcode field width
WAIT_MAX, 15, max cycles a memory state may wait for mem_ready before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  OPCODE_W  instruction register bits [31:26]
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
reg_dst  out  1  destination select: 0=rt, 1=rd
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=4, 10=signext, 11=signext<<2
alu_op  out  2  00=add, 01=sub, 10=funct-decoded
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
mem_timeout  out  1  one-cycle pulse on watchdog abort
illegal_op  out  1  unsupported opcode seen (see Optional Feature)

Behaviour:
- rst asserted (async): state=FETCH, wait_cnt=0.
  - While rst is high, all strobes are 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, mem_timeout, illegal_op.
  - All selects are 0 while rst is high.
- Outputs decode from state; memory-state strobes are additionally gated by mem_ready.
- States and outputs (unlisted outputs are 0):
  - FETCH: mem_read=1, i_or_d=0, alu_src_b=01, pc_source=00; ir_write=pc_write=mem_ready. Next: DECODE when mem_ready, else stay.
  - DECODE: alu_src_b=11.
    - Next by opcode: 000000→RTYPE_EX; 100011/101011→MEM_ADDR; 000100→BRANCH; 000010→JUMP; 001000→ADDI_EX.
    - Any other opcode → ILLEGAL.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10. Next: MEM_RD for 100011, MEM_WR for 101011.
  - MEM_RD: mem_read=1, i_or_d=1. Next: MEM_WB on mem_ready.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
  - MEM_WR: mem_write=1, i_or_d=1. Next: FETCH on mem_ready.
  - RTYPE_EX: alu_src_a=1, alu_op=10. Next: RTYPE_WB.
  - RTYPE_WB: reg_write=1, reg_dst=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
  - JUMP: pc_write=1, pc_source=10. Next: FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10. Next: ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0. Next: FETCH.
- opcode is sampled only in DECODE and MEM_ADDR; it may change in other states without effect.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - wait_cnt increments each cycle mem_ready=0 and clears on state exit.
  - When wait_cnt==WAIT_MAX with mem_ready=0: pulse mem_timeout, go to FETCH, clear wait_cnt. No strobe fires that cycle.
  - mem_ready=1 on the same cycle as wait_cnt==WAIT_MAX: the access completes normally and there is no timeout.
- Timeout from FETCH re-enters FETCH and does not update PC.
- Latency with mem_ready tied high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.

Optional Feature:
MIPS_CTRL_ILLEGAL_TRAP_EN
- Defined: ILLEGAL is terminal. illegal_op=1 and every strobe is 0 until rst.
- Undefined: ILLEGAL lasts one cycle, with illegal_op pulsed for that cycle, then returns to FETCH. The instruction acts as a NOP.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - alu_op, alu_src_b and pc_source encodings.
- Sub-module mips_mem_watchdog holds the wait_cnt counter and the timeout compare.

Test Plan:
- rst high mid-MEM_RD with mem_ready=0 → all strobes 0 immediately; after release, state FETCH with mem_read=1.
- mem_ready=1, opcode=000000 → states FETCH, DECODE, RTYPE_EX, RTYPE_WB; reg_write=1 and reg_dst=1 in cycle 4 only.
- opcode=100011, mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles; MEM_WB then asserts reg_write=1 and mem_to_reg=1 for 1 cycle.
- WAIT_MAX=15, mem_ready stuck 0 in FETCH → mem_timeout pulse at cycle 16; ir_write and pc_write never asserted.
- opcode=000100 → pc_write_cond=1, alu_op=01, pc_source=01 in cycle 3; opcode=000010 → pc_write=1, pc_source=10 in cycle 3.
- opcode=111111 → illegal_op=1; macro defined: held with strobes 0 for 10+ cycles; undefined: 1-cycle pulse, then FETCH.
